// File: rtl/fifo_pixel_reader_if.sv
// Read-side connection between the pixel reader and the display-path FIFO.
// master = the reader (pops), slave = the FIFO (status and head word).
interface fifo_pixel_reader_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  fifo_ren;
    logic                  fifo_empty;
    logic                  fifo_almost_empty;
    logic [DATA_WIDTH-1:0] fifo_read_data;

    modport master (
        output fifo_ren,
        input  fifo_empty,
        input  fifo_almost_empty,
        input  fifo_read_data
    );

    modport slave (
        input  fifo_ren,
        output fifo_empty,
        output fifo_almost_empty,
        output fifo_read_data
    );
endinterface

// File: rtl/fifo_pixel_reader.sv
// Consumer-side FIFO controller: primes on frame start, pops one word per pixel
// request, blanks on underflow. Define UNDERFLOW_COUNT_EN to add underflow_count.
module fifo_pixel_reader #(
    parameter int                    DATA_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] BLANK_VALUE = '0
`ifdef UNDERFLOW_COUNT_EN
    ,parameter int                   CNT_WIDTH   = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  pixel_en,
    fifo_pixel_reader_if.master   fifo,
    output logic [DATA_WIDTH-1:0] pixel_data,
    output logic                  pixel_valid,
    output logic                  underflow
`ifdef UNDERFLOW_COUNT_EN
    ,output logic [CNT_WIDTH-1:0] underflow_count
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] pixelData_q, pixelData_d;
    logic                  pixelValid_q, pixelValid_d;
    logic                  underflow_q, underflow_d;
    logic                  popEn;
    logic                  underflowHit;

    // Reset gates the pop so a mid-frame reset never consumes a word.
    always_comb begin
        popEn        = ~reset & ~frame_start & (state_q == S_STREAM) & pixel_en & ~fifo.fifo_empty;
        underflowHit = ~frame_start & (state_q == S_STREAM) & pixel_en & fifo.fifo_empty;
    end

    assign fifo.fifo_ren = popEn;

    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = S_PRIME;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_IDLE;
                S_PRIME:  state_d = fifo.fifo_almost_empty ? S_PRIME : S_STREAM;
                S_STREAM: state_d = S_STREAM;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pixelValid_d = pixel_en;
        pixelData_d  = pixelData_q;
        if (pixel_en) begin
            pixelData_d = popEn ? fifo.fifo_read_data : BLANK_VALUE;
        end
        underflow_d = frame_start ? 1'b0 : (underflow_q | underflowHit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pixelData_q  <= BLANK_VALUE;
            pixelValid_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pixelData_q  <= pixelData_d;
            pixelValid_q <= pixelValid_d;
            underflow_q  <= underflow_d;
        end
    end

    assign pixel_data  = pixelData_q;
    assign pixel_valid = pixelValid_q;
    assign underflow   = underflow_q;

`ifdef UNDERFLOW_COUNT_EN
    logic [CNT_WIDTH-1:0] underflowCount_q, underflowCount_d;

    // Saturates at all-ones so a long starved frame cannot wrap back to a small value.
    always_comb begin
        underflowCount_d = underflowCount_q;
        if (frame_start) begin
            underflowCount_d = '0;
        end else if (underflowHit && (underflowCount_q != {CNT_WIDTH{1'b1}})) begin
            underflowCount_d = underflowCount_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            underflowCount_q <= '0;
        end else begin
            underflowCount_q <= underflowCount_d;
        end
    end

    assign underflow_count = underflowCount_q;
`endif

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Self-checking bench for fifo_pixel_reader: directed vector table, corner
// sequences and random traffic against a behavioural FIFO plus reference model.
module tb_fifo_pixel_reader;

    localparam int DW    = 4;
    localparam int CW    = 8;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          frame_start;
    logic          pixel_en;
    logic [DW-1:0] pixel_data;
    logic          pixel_valid;
    logic          underflow;
`ifdef UNDERFLOW_COUNT_EN
    logic [CW-1:0] underflow_count;
`endif

    fifo_pixel_reader_if #(.DATA_WIDTH(DW)) fifoBus ();

    fifo_pixel_reader #(
        .DATA_WIDTH  (DW),
        .BLANK_VALUE ('0)
`ifdef UNDERFLOW_COUNT_EN
        ,.CNT_WIDTH  (CW)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pixel_en    (pixel_en),
        .fifo        (fifoBus),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .underflow   (underflow)
`ifdef UNDERFLOW_COUNT_EN
        ,.underflow_count (underflow_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Behavioural FIFO: queue contents plus a hysteretic almost-empty flag.
    logic [DW-1:0] fifoQ[$];
    bit            aeQ = 1'b1;

    // Reference model, expressed as frame/stream flags and expected outputs.
    bit            mFramed = 1'b0;
    bit            mStreaming = 1'b0;
    bit            mUnder = 1'b0;
    int            mCount = 0;
    bit            mValid = 1'b0;
    logic [DW-1:0] mData = '0;

    typedef struct {
        bit            frame;
        bit            pen;
        bit            wr;
        logic [DW-1:0] wd;
        bit            expRen;
        bit            expValid;
        logic [DW-1:0] expData;
        bit            expUnder;
    } vec_t;

    vec_t vecs[28];

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic driveFifo();
        fifoBus.fifo_empty        = (fifoQ.size() == 0);
        fifoBus.fifo_read_data    = (fifoQ.size() == 0) ? '0 : fifoQ[0];
        fifoBus.fifo_almost_empty = aeQ;
    endtask

    // One clock cycle: drive at negedge, check pop, clock, update FIFO and model, check outputs.
    task automatic applyStimulus(input bit rst, input bit frame, input bit pen,
                                 input bit wr, input logic [DW-1:0] wd, output bit renOut);
        bit            emptyPre;
        bit            aePre;
        bit            expPop;
        bit            renSeen;
        logic [DW-1:0] headPre;
        reset       = rst;
        frame_start = frame;
        pixel_en    = pen;
        emptyPre    = (fifoQ.size() == 0);
        headPre     = emptyPre ? '0 : fifoQ[0];
        aePre       = aeQ;
        expPop      = !rst && !frame && mStreaming && pen && !emptyPre;
        #1;
        renSeen = fifoBus.fifo_ren;
        checkOutput("fifo_ren", int'(renSeen), int'(expPop));
        renOut = renSeen;
        @(posedge clk);
        #1;
        if (renSeen && fifoQ.size() > 0) void'(fifoQ.pop_front());
        if (wr && fifoQ.size() < DEPTH) fifoQ.push_back(wd);
        if (fifoQ.size() >= 5) aeQ = 1'b0;
        else if (fifoQ.size() <= 1) aeQ = 1'b1;
        driveFifo();
        if (rst) begin
            mFramed = 0; mStreaming = 0; mUnder = 0; mCount = 0; mValid = 0; mData = '0;
        end else begin
            mValid = pen;
            if (pen) mData = expPop ? headPre : '0;
            if (frame) begin
                mFramed = 1; mStreaming = 0; mUnder = 0; mCount = 0;
            end else begin
                if (mStreaming && pen && emptyPre) begin
                    mUnder = 1;
                    if (mCount < (1 << CW) - 1) mCount++;
                end
                if (mFramed && !mStreaming && !aePre) mStreaming = 1;
            end
        end
        checkOutput("pixel_valid", int'(pixel_valid), int'(mValid));
        checkOutput("pixel_data", int'(pixel_data), int'(mData));
        checkOutput("underflow", int'(underflow), int'(mUnder));
`ifdef UNDERFLOW_COUNT_EN
        checkOutput("underflow_count", int'(underflow_count), mCount);
`endif
        @(negedge clk);
    endtask

    initial begin
        bit renOut;
        reset = 1'b1; frame_start = 1'b0; pixel_en = 1'b1;
        driveFifo();

        vecs[0] = '{1, 1, 0, 0, 0, 1, 0, 0};
        vecs[1] = '{0, 1, 1, 1, 0, 1, 0, 0};
        for (int i = 2; i <= 6; i++) vecs[i] = '{0, 0, 1, DW'(i), 0, 0, 0, 0};
        for (int i = 7; i <= 12; i++) vecs[i] = '{0, 1, 0, 0, 1, 1, DW'(i - 6), 0};
        for (int i = 13; i <= 15; i++) vecs[i] = '{0, 1, 0, 0, 0, 1, 0, 1};
        vecs[16] = '{1, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 17; i <= 23; i++) vecs[i] = '{0, 0, 1, DW'(i - 16), 0, 0, 0, 0};
        vecs[24] = '{1, 1, 0, 0, 0, 1, 0, 0};
        vecs[25] = '{0, 1, 0, 0, 0, 1, 0, 0};
        vecs[26] = '{0, 1, 0, 0, 1, 1, 1, 0};
        vecs[27] = '{0, 1, 0, 0, 1, 1, 2, 0};

        @(negedge clk);
        applyStimulus(1, 0, 1, 0, '0, renOut);
        applyStimulus(1, 0, 1, 0, '0, renOut);
        checkOutput("reset_pixel_valid", int'(pixel_valid), 0);
        checkOutput("reset_pixel_data", int'(pixel_data), 0);

        for (int i = 0; i < 28; i++) begin
            applyStimulus(0, vecs[i].frame, vecs[i].pen, vecs[i].wr, vecs[i].wd, renOut);
            checkOutput($sformatf("vec%0d_ren", i), int'(renOut), int'(vecs[i].expRen));
            checkOutput($sformatf("vec%0d_valid", i), int'(pixel_valid), int'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_data", i), int'(pixel_data), int'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_under", i), int'(underflow), int'(vecs[i].expUnder));
        end

        // Reset while streaming with data available must not pop.
        applyStimulus(1, 0, 1, 0, '0, renOut);
        checkOutput("midreset_ren", int'(renOut), 0);
        checkOutput("midreset_valid", int'(pixel_valid), 0);
        checkOutput("midreset_data", int'(pixel_data), 0);
        applyStimulus(0, 0, 1, 0, '0, renOut);
        checkOutput("idle_after_reset_ren", int'(renOut), 0);

        // Drain, then starve long enough to saturate the underflow counter.
        applyStimulus(0, 1, 0, 0, '0, renOut);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, DW'(i + 9), renOut);
        for (int i = 0; i < 270; i++) applyStimulus(0, 0, 1, 0, '0, renOut);
        checkOutput("starved_underflow", int'(underflow), 1);
`ifdef UNDERFLOW_COUNT_EN
        checkOutput("count_saturated", int'(underflow_count), (1 << CW) - 1);
`endif

        for (int i = 0; i < 600; i++) begin
            bit rst;
            bit frm;
            rst = ($urandom_range(0, 199) == 0);
            frm = ($urandom_range(0, 39) == 0);
            applyStimulus(rst, frm, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 5),
                          DW'($urandom), renOut);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
